// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified memory-port arbiter.
//   arb_state_t : arbiter FSM states (the owner of the port is implied by state)
//   mem_width_t : access width encoding carried on the MEM-stage side
//   FETCH_WIDTH : width used for every instruction fetch
//   cnt_width() : bit width needed to hold 0..max_wait
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        W_BYTE   = 2'd0,
        W_HALF   = 2'd1,
        W_WORD   = 2'd2,
        W_DOUBLE = 2'd3
    } mem_width_t;

    localparam mem_width_t FETCH_WIDTH = W_DOUBLE;

    function automatic int cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// mem_arb_starve_cnt
// Bounded-starvation tracker for the fetch requester. Counts data grants
// issued while a fetch is waiting and raises force_if once MAX_WAIT such
// grants have gone by, so the next arbitration hands the port to fetch.
//   clk, rst_n : clock, asynchronous active-low reset
//   if_req     : fetch request pending
//   if_grant   : fetch granted this cycle (clears the count)
//   dm_grant   : data granted this cycle (counts if a fetch is waiting)
//   force_if   : fetch must win the current arbitration
// ---------------------------------------------------------------------------
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_grant,
    input  logic dm_grant,
    output logic force_if
);

    localparam int              CNT_W   = cnt_width(MAX_WAIT);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] starve_cnt;

    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_grant) begin
            starve_cnt <= '0;
        end else if (dm_grant && if_req && (starve_cnt != MAX_CNT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Only meaningful while a fetch is actually waiting.
    assign force_if = if_req && (starve_cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF) and MEM-stage data
// accesses (DM). Data wins unless fetch has been starved for MAX_WAIT data
// grants. One transaction outstanding at a time; its completion is routed
// back to the requester that owns the port (implied by the FSM state).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata   fetch accept pulse, data-valid pulse, data
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_width/dm_sign   data request and its attributes, held to dm_gnt
//   dm_gnt/dm_rvalid/dm_rdata   data accept pulse, completion pulse, load data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_width/mem_sign  muxed request toward memory
//   mem_ready                   memory accepts mem_req this cycle
//   mem_rvalid/mem_rdata        completion of the outstanding request
//
// Optional build macro MEM_ARB_PERF_EN adds perf_if_stall[31:0], a saturating
// count of cycles in which fetch is requesting but not granted.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [1:0]            dm_width,
    input  logic                  dm_sign,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            mem_width,
    output logic                  mem_sign,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_if_stall
`endif
);

    arb_state_t state, state_next;
    logic       force_if;
    logic       sel_dm;

    mem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_grant (if_gnt),
        .dm_grant (dm_gnt),
        .force_if (force_if)
    );

    // Data has priority unless a starved fetch is owed the port.
    assign sel_dm = dm_req && !force_if;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case can leave one unassigned and infer a latch.
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_width  = 2'd0;
        mem_sign   = 1'b0;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        dm_rvalid  = 1'b0;
        if_rdata   = '0;
        dm_rdata   = '0;

        unique case (state)
            IDLE: begin
                // Stray mem_rvalid here has no owner and is ignored.
                if (sel_dm) begin
                    mem_req   = 1'b1;
                    mem_we    = dm_we;
                    mem_addr  = dm_addr;
                    mem_wdata = dm_wdata;
                    mem_width = dm_width;
                    mem_sign  = dm_sign;
                    if (mem_ready) begin
                        dm_gnt     = 1'b1;
                        state_next = BUSY_DM;
                    end
                end else if (if_req) begin
                    mem_req   = 1'b1;
                    mem_addr  = if_addr;
                    mem_width = FETCH_WIDTH;
                    mem_sign  = 1'b1;
                    if (mem_ready) begin
                        if_gnt     = 1'b1;
                        state_next = BUSY_IF;
                    end
                end
            end
            // Completion cycle issues nothing; next arbitration is in IDLE.
            BUSY_IF: begin
                if (mem_rvalid) begin
                    if_rvalid  = 1'b1;
                    if_rdata   = mem_rdata;
                    state_next = IDLE;
                end
            end
            BUSY_DM: begin
                if (mem_rvalid) begin
                    dm_rvalid  = 1'b1;
                    dm_rdata   = mem_rdata;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_stall <= '0;
        end else if (if_req && !if_gnt && (perf_if_stall != 32'hFFFF_FFFF)) begin
            perf_if_stall <= perf_if_stall + 32'd1;
        end
    end
`endif

    // Requests may not be withdrawn before they are granted.
    a_if_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (if_req && !if_gnt) |=> if_req);
    a_dm_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (dm_req && !dm_gnt) |=> dm_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (MAX_WAIT = 4). Inputs change on the
// falling edge; outputs are observed 1 ns later, away from the rising edge.
// Define MEM_ARB_PERF_EN to also exercise the fetch-stall counter.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_sign;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [1:0]    dm_width;
    logic          dm_gnt, dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_req, mem_we, mem_sign;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [1:0]    mem_width;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_if_stall;
`endif

    int n_checks = 0;
    int n_bad    = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_WAIT   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_width   (dm_width),
        .dm_sign    (dm_sign),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_width  (mem_width),
        .mem_sign   (mem_sign),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_stall (perf_if_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        if_req     = 1'b0;
        if_addr    = '0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        dm_addr    = '0;
        dm_wdata   = '0;
        dm_width   = 2'd0;
        dm_sign    = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();

        // ---------------- reset state ----------------
        #2;
        check("rst_mem_req",   mem_req,   0);
        check("rst_if_gnt",    if_gnt,    0);
        check("rst_dm_gnt",    dm_gnt,    0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_dm_rvalid", dm_rvalid, 0);
        check("rst_if_rdata",  if_rdata,  0);
        check("rst_dm_rdata",  dm_rdata,  0);
        check("rst_state",     dut.state, IDLE);
        check("rst_starve",    64'(dut.u_starve.starve_cnt), 0);

        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- single fetch ----------------
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h100; mem_ready = 1'b1;
        #1;
        check("f_if_gnt",    if_gnt,    1);
        check("f_dm_gnt",    dm_gnt,    0);
        check("f_mem_req",   mem_req,   1);
        check("f_mem_addr",  mem_addr,  64'h100);
        check("f_mem_we",    mem_we,    0);
        check("f_mem_width", mem_width, 3);
        check("f_mem_sign",  mem_sign,  1);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("f_busy_mem_req", mem_req,   0);
        check("f_busy_rvalid",  if_rvalid, 0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
        #1;
        check("f_if_rvalid", if_rvalid, 1);
        check("f_if_rdata",  if_rdata,  64'hDEAD);
        check("f_dm_rvalid", dm_rvalid, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("f_state_idle", dut.state, IDLE);

        // ---------------- simultaneous requests ----------------
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h200; dm_wdata = 64'h55;
        dm_width = 2'd2; dm_sign = 1'b0;
        if_req = 1'b1; if_addr = 64'h300;
        #1;
        check("s_dm_gnt",     dm_gnt,    1);
        check("s_if_gnt",     if_gnt,    0);
        check("s_mem_we",     mem_we,    1);
        check("s_mem_width",  mem_width, 2);
        check("s_mem_addr",   mem_addr,  64'h200);
        check("s_mem_wdata",  mem_wdata, 64'h55);
        @(negedge clk);
        dm_req = 1'b0;
        #1;
        check("s_busy_if_gnt", if_gnt, 0);
        check("s_starve_1",    64'(dut.u_starve.starve_cnt), 1);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = '0;
        #1;
        check("s_dm_rvalid",    dm_rvalid, 1);
        check("s_cmpl_if_gnt",  if_gnt,    0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("s_if_gnt",       if_gnt,    1);
        check("s_if_addr",      mem_addr,  64'h300);
        check("s_if_width",     mem_width, 3);
        @(negedge clk);
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h11;
        #1;
        check("s_starve_clr",   64'(dut.u_starve.starve_cnt), 0);
        check("s_if_rvalid",    if_rvalid, 1);
        @(negedge clk);
        mem_rvalid = 1'b0;

        // ---------------- starvation bound ----------------
        if_req = 1'b1; if_addr = 64'h600;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h700; dm_width = 2'd3; dm_sign = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            check($sformatf("st_if_gnt_%0d", k), if_gnt, (k == 5));
            check($sformatf("st_dm_gnt_%0d", k), dm_gnt, (k != 5));
            if (k == 1) check("st_mem_sign", mem_sign, 1);
            @(negedge clk);
            if (k == 5) if_req = 1'b0;
            mem_rvalid = 1'b1; mem_rdata = 64'(k);
            #1;
            check($sformatf("st_cnt_%0d", k), 64'(dut.u_starve.starve_cnt), (k == 5) ? 0 : k);
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        #1;
        check("st_last_dm_gnt", dm_gnt, 1);
        @(negedge clk);
        dm_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h99;
        #1;
        check("st_last_rvalid", dm_rvalid, 1);
        check("st_last_rdata",  dm_rdata,  64'h99);
        check("st_cnt_after",   64'(dut.u_starve.starve_cnt), 0);
        @(negedge clk);
        mem_rvalid = 1'b0;

        // ---------------- backpressure ----------------
        if_req = 1'b1; if_addr = 64'h400; mem_ready = 1'b0;
        #1;
        check("bp0_mem_req",  mem_req,  1);
        check("bp0_mem_addr", mem_addr, 64'h400);
        check("bp0_if_gnt",   if_gnt,   0);
        @(negedge clk);
        #1;
        check("bp1_if_gnt",   if_gnt,   0);
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h500; dm_width = 2'd1; dm_sign = 1'b0;
        #1;
        check("bp2_mem_addr", mem_addr, 64'h500);
        check("bp2_dm_gnt",   dm_gnt,   0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("bp3_dm_gnt",   dm_gnt,   1);
        check("bp3_if_gnt",   if_gnt,   0);
        @(negedge clk);
        dm_req = 1'b0;
        #1;
        check("bp_busy_ready_ignored", mem_req, 0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'hBEEF;
        #1;
        check("bp_dm_rvalid", dm_rvalid, 1);
        check("bp_dm_rdata",  dm_rdata,  64'hBEEF);
        check("bp_if_rvalid", if_rvalid, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("bp_if_gnt",    if_gnt,   1);
        @(negedge clk);
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h4;
        @(negedge clk);
        mem_rvalid = 1'b0;

        // ---------------- stray rvalid and reset ----------------
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        #1;
        check("stray_if_rvalid", if_rvalid, 0);
        check("stray_dm_rvalid", dm_rvalid, 0);
        check("stray_dm_rdata",  dm_rdata,  0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("stray_state", dut.state, IDLE);
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h800;
        #1;
        check("rst_dm_gnt_pre", dm_gnt, 1);
        @(negedge clk);
        dm_req = 1'b0;
        #1;
        check("rst_busy_dm", dut.state, BUSY_DM);
        rst_n = 1'b0;
        #1;
        check("rst_async_state", dut.state, IDLE);
        check("rst_async_req",   mem_req,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 64'h77;
        #1;
        check("late_dm_rvalid", dm_rvalid, 0);
        check("late_dm_rdata",  dm_rdata,  0);
        check("late_if_rvalid", if_rvalid, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;

`ifdef MEM_ARB_PERF_EN
        // ---------------- fetch stall counter ----------------
        #1;
        check("perf_zero", perf_if_stall, 0);
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h900; if_req = 1'b1; if_addr = 64'hA00;
        #1;
        check("perf_dm_gnt", dm_gnt, 1);
        @(negedge clk);
        dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("perf_if_gnt", if_gnt, 1);
        check("perf_count",  perf_if_stall, 5);
        @(negedge clk);
        if_req = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("perf_hold", perf_if_stall, 5);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
